// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state enums plus status bit positions for alu_multicycle
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL1,
        OP_SHR1,
        OP_MUL
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } alu_state_e;

    localparam int ST_ZERO   = 0;
    localparam int ST_ONES   = 1;
    localparam int ST_CARRY  = 2;
    localparam int ST_PARITY = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_BITS   = 5;

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request, operand and result signals of the multicycle ALU
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] ALU_in1;
    logic [WIDTH-1:0] ALU_in2;
    logic [2:0]       ALU_op;
    logic             ALU_start;
    logic             ALU_status_out_en;
    logic [WIDTH-1:0] ALU_out;
    logic             ALU_busy;
    logic             ALU_done;
    logic             ALU_err;

    modport master (
        output ALU_in1, ALU_in2, ALU_op, ALU_start, ALU_status_out_en,
        input  ALU_out, ALU_busy, ALU_done, ALU_err
    );

    modport slave (
        input  ALU_in1, ALU_in2, ALU_op, ALU_start, ALU_status_out_en,
        output ALU_out, ALU_busy, ALU_done, ALU_err
    );
endinterface

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative shift-add multiplier, one partial product per cycle
module alu_shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    // load on start, then add/shift for WIDTH cycles and pulse done once the product is final
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= '0;
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                cnt     <= '0;
                run     <= 1'b1;
            end else if (run) begin
                if (mplier[0])
                    product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: multicycle ALU with result/status registers; ALU_MULTICYCLE_MUL_EN enables the iterative multiplier
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    alu_multicycle_if.slave bus
);
`ifdef ALU_MULTICYCLE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_state_e         state;
    alu_state_e         state_n;
    alu_op_e            op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic [ST_BITS-1:0] status_q;
    logic               err_q;
    logic [WIDTH-1:0]   res_c;
    logic [ST_BITS-1:0] status_c;
    logic               carry_c;
    logic               ovf_c;
    logic               err_c;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               mul_done;
    logic               finish;

`ifdef ALU_MULTICYCLE_MUL_EN
    logic [2*WIDTH-1:0] product;

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (state == IDLE && bus.ALU_start && bus.ALU_op == OP_MUL),
        .a       (bus.ALU_in1),
        .b       (bus.ALU_in2),
        .done    (mul_done),
        .product (product)
    );
`else
    assign mul_done = 1'b0;
`endif

    assign finish       = (state == EXEC) || (state == MUL && mul_done);
    assign bus.ALU_busy = (state == EXEC) || (state == MUL);
    assign bus.ALU_done = (state == DONE);
    assign bus.ALU_err  = (state == DONE) && err_q;
    assign bus.ALU_out  = bus.ALU_status_out_en ? WIDTH'(status_q) : result_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state: multiply runs in MUL until the multiplier finishes, everything else takes one EXEC cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.ALU_start ? ((MUL_EN && bus.ALU_op == OP_MUL) ? MUL : EXEC) : IDLE;
            EXEC:    state_n = DONE;
            MUL:     state_n = mul_done ? DONE : MUL;
            default: state_n = IDLE;
        endcase
    end

    // operands and opcode are captured only when a request is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else if (state == IDLE && bus.ALU_start) begin
            a_q  <= bus.ALU_in1;
            b_q  <= bus.ALU_in2;
            op_q <= alu_op_e'(bus.ALU_op);
        end
    end

    // result datapath and status flags derived from the latched operands
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff[WIDTH-1:0];
                carry_c = diff[WIDTH];
                ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_c = a_q & b_q;
            OP_OR:   res_c = a_q | b_q;
            OP_XOR:  res_c = a_q ^ b_q;
            OP_SHL1: begin
                res_c   = {a_q[WIDTH-2:0], 1'b0};
                carry_c = a_q[WIDTH-1];
            end
            OP_SHR1: begin
                res_c   = {1'b0, a_q[WIDTH-1:1]};
                carry_c = a_q[0];
            end
            default: begin
`ifdef ALU_MULTICYCLE_MUL_EN
                res_c   = product[WIDTH-1:0];
                carry_c = |product[2*WIDTH-1:WIDTH];
`else
                err_c   = 1'b1;
`endif
            end
        endcase
        status_c            = '0;
        status_c[ST_ZERO]   = (res_c == '0);
        status_c[ST_ONES]   = &res_c;
        status_c[ST_CARRY]  = carry_c;
        status_c[ST_PARITY] = ^res_c;
        status_c[ST_OVF]    = ovf_c;
    end

    // result, status and error flag update only when an operation completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else if (finish) begin
            result_q <= res_c;
            status_q <= status_c;
            err_q    <= err_c;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
    localparam int W = 16;
`ifdef ALU_MULTICYCLE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input longint a, input longint b, input int op,
                                  output longint r, output int st, output int err, output int lat);
        longint mask = (longint'(1) << W) - 1;
        longint half = longint'(1) << (W - 1);
        longint sa = (a >= half) ? a - (mask + 1) : a;
        longint sb = (b >= half) ? b - (mask + 1) : b;
        longint full = 0;
        int c = 0;
        int v = 0;
        err = 0;
        lat = 2;
        case (op)
            0: begin full = a + b; c = int'(full > mask); v = int'(sa + sb >= half || sa + sb < -half); end
            1: begin full = a - b; c = int'(a < b); v = int'(sa - sb >= half || sa - sb < -half); end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: begin full = a << 1; c = int'((a >> (W - 1)) & 1); end
            6: begin full = a >> 1; c = int'(a & 1); end
            default: begin
                if (MUL_ON) begin
                    full = a * b;
                    c = int'((full >> W) != 0);
                    lat = W + 2;
                end else begin
                    full = 0;
                    err = 1;
                end
            end
        endcase
        r = full & mask;
        st = int'(r == 0) | (int'(r == mask) << 1) | (c << 2) | (($countones(r) & 1) << 3) | (v << 4);
    endfunction

    task automatic do_op(input longint a, input longint b, input int op, input bit noise, input string tag);
        longint r;
        int st, err, lat, cyc;
        bit seen = 1'b0;
        model(a, b, op, r, st, err, lat);
        bus.ALU_in1 = W'(a);
        bus.ALU_in2 = W'(b);
        bus.ALU_op = 3'(op);
        bus.ALU_start = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ALU_done) begin
                seen = 1'b1;
                break;
            end
            check({tag, " busy"}, 32'(bus.ALU_busy), 1);
            bus.ALU_start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                bus.ALU_in1 = W'($urandom);
                bus.ALU_in2 = W'($urandom);
                bus.ALU_op = 3'($urandom);
            end
        end
        bus.ALU_start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " out"}, 32'(bus.ALU_out), 32'(r));
        check({tag, " err"}, 32'(bus.ALU_err), err);
        check({tag, " busy_in_done"}, 32'(bus.ALU_busy), 0);
        bus.ALU_status_out_en = 1'b1;
        #1;
        check({tag, " status"}, 32'(bus.ALU_out), st);
        bus.ALU_status_out_en = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(bus.ALU_done), 0);
        check({tag, " err_pulse"}, 32'(bus.ALU_err), 0);
        check({tag, " hold"}, 32'(bus.ALU_out), 32'(r));
    endtask

    initial begin
        int abort_cyc;
        bit any_done;
        rst = 1'b1;
        bus.ALU_in1 = '0;
        bus.ALU_in2 = '0;
        bus.ALU_op = '0;
        bus.ALU_start = 1'b0;
        bus.ALU_status_out_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.ALU_busy), 0);
        check("reset done", 32'(bus.ALU_done), 0);
        check("reset err", 32'(bus.ALU_err), 0);
        check("reset out", 32'(bus.ALU_out), 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'hFFFF, 16'h0001, 0, 1'b0, "add_wrap");
        do_op(16'h8000, 16'h0001, 1, 1'b0, "sub_ovf");
        do_op(16'h0100, 16'h0100, 7, 1'b1, "mul_big");
        do_op(16'h0001, 16'h0000, 6, 1'b0, "shr1");
        do_op(16'h8001, 16'h0000, 5, 1'b0, "shl1");
        do_op(16'h00FF, 16'h0F0F, 2, 1'b0, "and");
        do_op(16'hF000, 16'h0FFF, 3, 1'b0, "or_ones");
        do_op(16'h1234, 16'h1234, 4, 1'b0, "xor_zero");
        do_op(16'h7FFF, 16'h0001, 0, 1'b0, "add_ovf");

        for (int i = 0; i < 40; i++)
            do_op(longint'($urandom_range(0, 16'hFFFF)), longint'($urandom_range(0, 16'hFFFF)),
                  int'($urandom_range(0, 7)), 1'($urandom), "rand");

        do_op(2, 3, 0, 1'b0, "add_pre");
        abort_cyc = MUL_ON ? 5 : 1;
        bus.ALU_in1 = 16'h0003;
        bus.ALU_in2 = 16'h0005;
        bus.ALU_op = 3'd7;
        bus.ALU_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ALU_start = 1'b0;
        repeat (abort_cyc - 1) @(negedge clk);
        check("abort busy_before", 32'(bus.ALU_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(bus.ALU_busy), 0);
        check("abort done", 32'(bus.ALU_done), 0);
        check("abort out", 32'(bus.ALU_out), 0);
        bus.ALU_status_out_en = 1'b1;
        #1;
        check("abort status", 32'(bus.ALU_out), 0);
        bus.ALU_status_out_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            any_done = any_done | bus.ALU_done;
        end
        check("abort no_done", 32'(any_done), 0);
        do_op(2, 3, 0, 1'b0, "add_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
